// File: rtl/interleaver_scheduler_pkg.sv
// interleaver_scheduler_pkg: shared widths, defaults and FSM state type for the interleaver scheduler
package interleaver_scheduler_pkg;
    localparam int SCALING_FACTOR_BITWIDTH = 12;
    localparam int CTRL_SLOTS = 16;
    localparam logic [11:0] CTRL_IDLE_WORD = 12'h000;
    typedef enum logic {S_IDLE, S_RUN} sched_state_t;
endpackage

// File: rtl/interleaver_scheduler_if.sv
// interleaver_scheduler_if: framing, scaling-factor, requester and interleaver-side signals of the scheduler
// master drives en/comma_residual/sf_in/sf_valid/req_valid/req_word; slave (scheduler) drives
// req_ready/comma/scaling_factor_o/control_data/frame_start.
interface interleaver_scheduler_if import interleaver_scheduler_pkg::*; #(parameter int NUM_REQ = 4);
    logic                               en;
    logic [7:0]                         comma_residual;
    logic [SCALING_FACTOR_BITWIDTH-1:0] sf_in;
    logic                               sf_valid;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ*12-1:0]              req_word;
    logic [NUM_REQ-1:0]                 req_ready;
    logic                               comma;
    logic [SCALING_FACTOR_BITWIDTH-1:0] scaling_factor_o;
    logic [11:0]                        control_data;
    logic                               frame_start;
    modport master (
        output en, comma_residual, sf_in, sf_valid, req_valid, req_word,
        input  req_ready, comma, scaling_factor_o, control_data, frame_start
    );
    modport slave (
        input  en, comma_residual, sf_in, sf_valid, req_valid, req_word,
        output req_ready, comma, scaling_factor_o, control_data, frame_start
    );
endinterface

// File: rtl/interleaver_scheduler_rr_arbiter.sv
// interleaver_scheduler_rr_arbiter: round-robin arbiter, search starts just after the last granted index
// clk/rst: clock and sync reset; req: requests; enable: allow a grant this cycle;
// update: advance the pointer to the granted index; grant: one-hot grant.
module interleaver_scheduler_rr_arbiter #(parameter int N = 4) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         enable,
    input  logic         update,
    output logic [N-1:0] grant
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] ptr, gidx, j;
    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        grant = '0;
        gidx = ptr;
        j = '0;
        for (int i = N; i >= 1; i--) begin
            j = PW'((int'(ptr) + i) % N);
            if (req[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                gidx = j;
            end
        end
        if (!enable) grant = '0;
    end
    always_ff @(posedge clk)
        ptr <= rst ? PW'(N - 1) : (update && |grant) ? gidx : ptr;
endmodule

// File: rtl/interleaver_scheduler.sv
// interleaver_scheduler: frame/comma generator, scaling-factor side word and control-slot arbiter for the interleaver
// clk/rst: clock and sync active-high reset; io (slave): en, comma_residual, sf_in/sf_valid, req_valid/req_word
// in; req_ready, comma, scaling_factor_o, control_data, frame_start out.
module interleaver_scheduler import interleaver_scheduler_pkg::*; #(
    parameter int          NUM_REQ   = 4,
    parameter int          SLOTS     = CTRL_SLOTS,
    parameter logic [11:0] IDLE_WORD = CTRL_IDLE_WORD
) (
    input logic clk,
    input logic rst,
    interleaver_scheduler_if.slave io
);
    localparam int FRAME_LEN = 3 * SLOTS + 2;
    localparam int CW = $clog2(FRAME_LEN);
    if (NUM_REQ < 2 || NUM_REQ > 8 || SLOTS < 2) begin : g_param_check
        $error("interleaver_scheduler: NUM_REQ must be 2..8 and SLOTS >= 2");
    end
    sched_state_t state, state_n;
    logic [CW-1:0] cyc, cyc_n;
    logic [SCALING_FACTOR_BITWIDTH-1:0] sf_shadow, sf_active;
    logic [NUM_REQ-1:0] arb_req, grant;
    logic [11:0] word;
    logic run, last, arb, upd;
    int c;
    // Arbitration runs one cycle before each control-slot load cycle (cyc 3,6,..,3*(SLOTS-1)); the
    // dead-slot cycle 3*SLOTS and cyc 0 only reload IDLE_WORD. Slot 1 forces requester 0 when valid.
    always_comb begin
        c = int'(cyc);
        run = state == S_RUN;
        last = c == FRAME_LEN - 1;
        state_n = (state == S_IDLE) ? (io.en ? S_RUN : S_IDLE) : ((last && !io.en) ? S_IDLE : S_RUN);
        cyc_n = (state == S_IDLE || last) ? '0 : cyc + 1'b1;
        arb = run && c > 0 && c % 3 == 0 && c < 3 * SLOTS;
        upd = run && c % 3 == 0;
        arb_req = (c == 3 && io.req_valid[0]) ? NUM_REQ'(1) : io.req_valid;
        word = IDLE_WORD;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) word = io.req_word[12*i +: 12];
    end
    interleaver_scheduler_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk(clk),
        .rst(rst),
        .req(arb_req),
        .enable(arb),
        .update(arb),
        .grant(grant)
    );
    assign io.req_ready = grant;
    assign io.frame_start = io.comma;
    assign io.scaling_factor_o = (run && c == 0) ? {{(SCALING_FACTOR_BITWIDTH-8){1'b0}}, io.comma_residual}
                               : (run && c == 1) ? sf_active : '0;
    always_ff @(posedge clk) begin
        state <= rst ? S_IDLE : state_n;
        cyc <= rst ? '0 : cyc_n;
        io.comma <= !rst && state_n == S_RUN && cyc_n == '0;
        sf_shadow <= rst ? '0 : io.sf_valid ? io.sf_in : sf_shadow;
        sf_active <= rst ? '0 : (run && c == 0) ? sf_shadow : sf_active;
        io.control_data <= rst ? IDLE_WORD : upd ? word : io.control_data;
    end
endmodule

// File: tb/tb_interleaver_scheduler.sv
// tb_interleaver_scheduler: directed and randomized checks of the scheduler against a frame-level reference model
module tb_interleaver_scheduler;
    import interleaver_scheduler_pkg::*;
    localparam int NR = 4;
    localparam int SL = 4;
    localparam int FL = 3 * SL + 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    interleaver_scheduler_if #(.NUM_REQ(NR)) ifc();
    interleaver_scheduler #(.NUM_REQ(NR), .SLOTS(SL), .IDLE_WORD(12'h000)) dut (
        .clk(clk),
        .rst(rst),
        .io(ifc)
    );
    int checks = 0;
    int errors = 0;
    int t = 0;
    bit m_run = 0;
    int m_pos = 0;
    int m_rr = NR - 1;
    logic [11:0] m_shadow = '0;
    logic [11:0] m_active = '0;
    logic [11:0] exp_ctrl [int];
    int comma_t[$];
    int grants[$];
    logic [NR-1:0] last_ready;
    int t_en;
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, t=%0d", t);
        $fatal(1, "watchdog expired");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask
    // Slot k = pos/3 (k=1..SL-1) is arbitrated at pos 3k; slot 1 favours requester 0.
    function automatic int exp_grant();
        if (!(m_run && m_pos > 0 && m_pos % 3 == 0 && m_pos / 3 < SL)) return -1;
        if (m_pos == 3 && ifc.req_valid[0]) return 0;
        for (int i = 1; i <= NR; i++)
            if (ifc.req_valid[(m_rr + i) % NR]) return (m_rr + i) % NR;
        return -1;
    endfunction
    task automatic step();
        int g;
        logic [11:0] ec;
        #3;
        g = exp_grant();
        ec = exp_ctrl.exists(t) ? exp_ctrl[t] : 12'h000;
        last_ready = ifc.req_ready;
        chk("comma", ifc.comma, m_run && m_pos == 0);
        chk("frame_start", ifc.frame_start, m_run && m_pos == 0);
        chk("scaling_factor_o", ifc.scaling_factor_o,
            !m_run ? 0 : m_pos == 0 ? {4'h0, ifc.comma_residual} : m_pos == 1 ? m_active : 0);
        chk("req_ready", ifc.req_ready, g < 0 ? 0 : 1 << g);
        chk("control_data", ifc.control_data, ec);
        if (ifc.comma) comma_t.push_back(t);
        for (int i = 0; i < NR; i++) if (ifc.req_ready[i]) grants.push_back(i);
        if (rst) begin
            m_run = 0; m_pos = 0; m_shadow = '0; m_active = '0; m_rr = NR - 1;
            for (int k = t + 1; k <= t + 3; k++) exp_ctrl.delete(k);
        end else begin
            if (m_run && m_pos == 0) m_active = m_shadow;
            if (ifc.sf_valid) m_shadow = ifc.sf_in;
            if (g >= 0) begin
                for (int k = 1; k <= 3; k++) exp_ctrl[t + k] = ifc.req_word[12*g +: 12];
                m_rr = g;
            end
            if (!m_run) begin
                if (ifc.en) begin m_run = 1; m_pos = 0; end
            end else if (m_pos == FL - 1) begin
                if (ifc.en) m_pos = 0; else m_run = 0;
            end else m_pos++;
        end
        @(posedge clk);
        #1;
        t++;
    endtask
    task automatic run_to(input int p);
        for (int n = 0; n < 3 * FL && !(m_run && m_pos == p); n++) step();
        if (!(m_run && m_pos == p)) begin
            checks++;
            errors++;
            $error("FAIL run_to pos=%0d not reached, t=%0d", p, t);
        end
    endtask
    initial begin
        ifc.en = 0; ifc.comma_residual = '0; ifc.sf_in = '0; ifc.sf_valid = 0;
        ifc.req_valid = '0; ifc.req_word = '0;
        rst = 1;
        @(posedge clk);
        #1;
        step();
        rst = 0;
        step();
        // Framing: commas at en+1, +FL, +2FL; no requests means idle slots throughout.
        comma_t.delete();
        ifc.en = 1;
        t_en = t;
        for (int n = 0; n < 3 * FL; n++) begin
            ifc.comma_residual = 8'($urandom);
            step();
        end
        chk("comma_count", comma_t.size(), 3);
        chk("comma_first", comma_t[0], t_en + 1);
        chk("comma_second", comma_t[1], t_en + 1 + FL);
        chk("comma_third", comma_t[2], t_en + 1 + 2 * FL);
        // Scaling factor: mid-frame write shows next frame; comma-cycle write one frame later.
        run_to(5);
        ifc.sf_in = 12'hABC; ifc.sf_valid = 1;
        step();
        ifc.sf_valid = 0;
        run_to(1);
        chk("sf_next_frame", ifc.scaling_factor_o, 12'hABC);
        run_to(0);
        ifc.sf_in = 12'h123; ifc.sf_valid = 1;
        step();
        ifc.sf_valid = 0;
        chk("sf_comma_write_deferred", ifc.scaling_factor_o, 12'hABC);
        step();
        run_to(1);
        chk("sf_comma_write_applied", ifc.scaling_factor_o, 12'h123);
        // Round-robin with all requesters permanently valid, starting from reset.
        rst = 1;
        step();
        rst = 0;
        ifc.req_valid = '1;
        for (int i = 0; i < NR; i++) ifc.req_word[12*i +: 12] = 12'h100 * 12'(i + 1) + 12'(i);
        grants.delete();
        for (int n = 0; n < 2 * FL + 1; n++) begin
            step();
            for (int i = 0; i < NR; i++) if (last_ready[i]) ifc.req_word[12*i +: 12] = 12'($urandom);
        end
        chk("rr_grant_count", grants.size(), 6);
        for (int i = 0; i < 6; i++) chk("rr_grant_order", grants[i], i % 3);
        // Slot-1 priority: req 2 waiting from the previous frame, req 0 arrives at pos 2.
        ifc.req_valid = '0;
        run_to(10);
        ifc.req_valid[2] = 1; ifc.req_word[24 +: 12] = 12'h2A2;
        run_to(2);
        ifc.req_valid[0] = 1; ifc.req_word[0 +: 12] = 12'h0B0;
        step();
        chk("slot1_priority", ifc.req_ready, 4'b0001);
        step();
        ifc.req_valid[0] = 0;
        run_to(6);
        chk("slot2_req2", ifc.req_ready, 4'b0100);
        step();
        ifc.req_valid[2] = 0;
        chk("slot2_data", ifc.control_data, 12'h2A2);
        // Randomized traffic with protocol-respecting requesters, sf writes, en and rst toggles.
        for (int n = 0; n < 600; n++) begin
            ifc.comma_residual = 8'($urandom);
            ifc.sf_valid = ($urandom_range(7) == 0);
            ifc.sf_in = 12'($urandom);
            if ($urandom_range(39) == 0) ifc.en = ~ifc.en;
            rst = ($urandom_range(199) == 0);
            for (int i = 0; i < NR; i++) begin
                if (ifc.req_valid[i] && last_ready[i]) begin
                    ifc.req_valid[i] = 1'($urandom);
                    ifc.req_word[12*i +: 12] = 12'($urandom);
                end else if (ifc.req_valid[i]) begin
                    if ($urandom_range(15) == 0) ifc.req_valid[i] = 0;
                end else if ($urandom_range(3) == 0) begin
                    ifc.req_valid[i] = 1;
                    ifc.req_word[12*i +: 12] = 12'($urandom);
                end
            end
            step();
        end
        rst = 0; ifc.sf_valid = 0; ifc.req_valid = '0;
        // en dropped at pos 5: the frame completes and no further comma follows.
        rst = 1;
        step();
        rst = 0;
        ifc.en = 1;
        run_to(5);
        ifc.en = 0;
        step();
        comma_t.delete();
        for (int n = 0; n < 2 * FL; n++) step();
        chk("no_comma_after_drop", comma_t.size(), 0);
        // rst at pos 7 aborts the frame; re-enable gives a comma one cycle after en.
        ifc.en = 1;
        run_to(7);
        rst = 1;
        step();
        rst = 0; ifc.en = 0;
        chk("rst_comma", ifc.comma, 0);
        chk("rst_control_data", ifc.control_data, 12'h000);
        chk("rst_scaling", ifc.scaling_factor_o, 0);
        step();
        step();
        ifc.en = 1;
        step();
        chk("reenable_comma", ifc.comma, 1);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
